// File: rtl/sum_of_squares_seq_if.sv
// Handshake bundle between a sample source, sum_of_squares_seq and the downstream sqrt stage.
// The master modport is the sample source and result consumer; the slave modport is the block itself.
interface sum_of_squares_seq_if #(
  parameter int N = 16
);
  localparam int W = N / 2;

  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        sum;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    output x, y, in_valid, out_ready,
    input  in_ready, sum, out_valid, busy
  );

  modport slave (
    input  x, y, in_valid, out_ready,
    output in_ready, sum, out_valid, busy
  );
endinterface

// File: rtl/sum_of_squares_seq.sv
// Sequential x*x + y*y using one shared shift-add multiplier, W steps per operand.
// The result feeds the num/valid/ready input of the sequential square-root block.
module sum_of_squares_seq #(
  parameter int N = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  sum_of_squares_seq_if.slave     io,
  output logic [1:0]              state_o
);
  localparam int W     = N / 2;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_X = 2'd1,
    MUL_Y = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [N-1:0]     sum_q;
  logic [N-1:0]     acc_q;
  logic [N-1:0]     acc_d;
  logic [N-1:0]     mcand_q;
  logic [W-1:0]     mplier_q;
  logic [W-1:0]     y_mag_q;
  logic [CNT_W-1:0] cnt_q;

  // Magnitude as unsigned W bits: the most negative value maps to 2^(W-1), which still fits.
  function automatic logic [W-1:0] abs_mag(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = v;
    return v[W-1] ? (~u + 1'b1) : u;
  endfunction

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the producer holds its data until that edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      y_mag_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ready_q && io.in_valid) begin
            in_ready_q <= 1'b0;
            mcand_q    <= N'(abs_mag(io.x));
            mplier_q   <= abs_mag(io.x);
            y_mag_q    <= abs_mag(io.y);
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= MUL_X;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        MUL_X: begin
          acc_q <= acc_d;
          if (cnt_q == CNT_LAST) begin
            mcand_q  <= N'(y_mag_q);
            mplier_q <= y_mag_q;
            cnt_q    <= '0;
            state_q  <= MUL_Y;
          end else begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        MUL_Y: begin
          acc_q <= acc_d;
          if (cnt_q == CNT_LAST) begin
            sum_q       <= acc_d;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end else begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_valid_q && io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.sum       = sum_q;
  assign io.busy      = (state_q != IDLE);
  assign state_o      = state_q;
endmodule

// File: tb/tb_sum_of_squares_seq.sv
// Directed bench for sum_of_squares_seq at N = 16: latency, corner magnitudes, backpressure,
// input churn with back-to-back accepts, and reset in the middle of a computation.
module tb_sum_of_squares_seq;
  localparam int N = 16;
  localparam int W = N / 2;
  localparam int LAT = 2 * W;

  logic       clk;
  logic       reset_n;
  logic [1:0] state_o;
  int         checks;
  int         failures;

  sum_of_squares_seq_if #(.N(N)) io ();

  sum_of_squares_seq #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io),
    .state_o (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: everything happens 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Accept one pair (in_ready must already be high), then wait for out_valid.
  task automatic run_pair(input logic signed [W-1:0] xv, input logic signed [W-1:0] yv,
                          input logic [N-1:0] exp_sum, input string tag);
    int lat;
    check({tag, "_in_ready_pre"}, 32'(io.in_ready), 32'd1);
    io.x = xv;
    io.y = yv;
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    check({tag, "_in_ready_drop"}, 32'(io.in_ready), 32'd0);
    check({tag, "_busy"}, 32'(io.busy), 32'd1);
    lat = 0;
    while (!io.out_valid && lat < 4 * LAT) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_sum"}, 32'(io.sum), 32'(exp_sum));
  endtask

  // With out_ready high, the handshake edge returns the block to IDLE.
  task automatic finish_pair(input string tag);
    io.out_ready = 1'b1;
    step();
    check({tag, "_out_valid_pulse"}, 32'(io.out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(io.in_ready), 32'd1);
    check({tag, "_busy_idle"}, 32'(io.busy), 32'd0);
  endtask

  initial begin
    int t;
    int accept_t;
    int seen_ov;
    logic ir;

    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    io.x = '0;
    io.y = '0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(io.in_ready), 32'd0);
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_sum", 32'(io.sum), 32'd0);
    check("rst_busy", 32'(io.busy), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    reset_n = 1'b1;
    step();
    check("rel_in_ready", 32'(io.in_ready), 32'd1);

    // Basic 3-4-5
    run_pair(8'sd3, 8'sd4, 16'd25, "p34");
    finish_pair("p34");

    // Most negative abs() and full range
    run_pair(-8'sd128, -8'sd128, 16'h8000, "pm128");
    finish_pair("pm128");
    run_pair(8'sd127, -8'sd128, 16'd32513, "p127");
    finish_pair("p127");

    // Zero and small signed values
    run_pair(8'sd0, 8'sd0, 16'd0, "p00");
    finish_pair("p00");
    run_pair(-8'sd1, 8'sd1, 16'd2, "pm11");
    finish_pair("pm11");

    // Backpressure, with ignored input pulses while waiting
    io.out_ready = 1'b0;
    run_pair(8'sd5, 8'sd12, 16'd169, "bp");
    for (int i = 0; i < 5; i++) begin
      io.x = 8'sd9;
      io.y = 8'sd9;
      io.in_valid = i[0];
      step();
      check("bp_hold_valid", 32'(io.out_valid), 32'd1);
      check("bp_hold_sum", 32'(io.sum), 32'd169);
      check("bp_hold_in_ready", 32'(io.in_ready), 32'd0);
    end
    io.in_valid = 1'b0;
    finish_pair("bp");
    step();
    check("bp_single_hs", 32'(io.out_valid), 32'd0);
    check("bp_idle_in_ready", 32'(io.in_ready), 32'd1);
    check("bp_sum_kept", 32'(io.sum), 32'd169);

    // Input churn after accept, in_valid held high for a back-to-back accept
    io.out_ready = 1'b1;
    io.x = 8'sd6;
    io.y = 8'sd8;
    io.in_valid = 1'b1;
    check("churn_in_ready_pre", 32'(io.in_ready), 32'd1);
    step();
    t = 0;
    accept_t = -1;
    seen_ov = 0;
    while (accept_t < 0 && t < 4 * LAT) begin
      io.x = 8'($urandom_range(0, 255));
      io.y = 8'($urandom_range(0, 255));
      ir = io.in_ready;
      step();
      t++;
      if (io.out_valid) begin
        seen_ov++;
        check("churn_latency", 32'(t), 32'(LAT));
        check("churn_sum", 32'(io.sum), 32'd100);
      end
      if (ir) accept_t = t;
    end
    check("churn_seen_valid", 32'(seen_ov), 32'd1);
    check("b2b_accept_gap", 32'(accept_t), 32'(LAT + 2));
    io.in_valid = 1'b0;
    t = 0;
    while (!io.out_valid && t < 4 * LAT) begin
      step();
      t++;
    end
    check("b2b_latency", 32'(t), 32'(LAT));
    finish_pair("b2b");

    // Reset during MUL_Y
    io.x = 8'sd2;
    io.y = 8'sd3;
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) step();
    check("mid_state_muly", 32'(state_o), 32'd2);
    reset_n = 1'b0;
    step();
    check("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    check("mid_rst_sum", 32'(io.sum), 32'd0);
    check("mid_rst_in_ready", 32'(io.in_ready), 32'd0);
    check("mid_rst_busy", 32'(io.busy), 32'd0);
    reset_n = 1'b1;
    step();
    check("mid_rel_in_ready", 32'(io.in_ready), 32'd1);
    seen_ov = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (io.out_valid) seen_ov++;
    end
    check("mid_no_stale", 32'(seen_ov), 32'd0);
    run_pair(8'sd1, 8'sd1, 16'd2, "p11");
    finish_pair("p11");

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sum_of_squares_seq.md
Name: sum_of_squares_seq

Overview:
- Sequential front-end for the square-root stage. Accepts one signed sample pair (x, y) and computes the exact magnitude-squared x*x + y*y.
- Uses a single shared shift-add multiplier iterated over fixed cycles.
- Presents the N-bit unsigned result on a valid/ready output that connects directly to the num/valid/ready input of the sequential square-root block.
- Together the two blocks form a |(x, y)| magnitude path.

Parameters:
- N, 16, result width. Must be even and >= 4. Equals the downstream sqrt input width.
- W, N/2, derived localparam (not overridable): width of each signed input sample.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- x  input  W  signed sample, two's complement
- y  input  W  signed sample, two's complement
- in_valid  input  1  x/y valid
- in_ready  output  1  block can accept a pair
- sum  output  N  unsigned x*x + y*y
- out_valid  output  1  sum valid
- out_ready  input  1  downstream accepts sum
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (reset_n = 0 at a clock edge):
  - state = IDLE, in_ready = 0, out_valid = 0, sum = 0, busy = 0.
  - Internal accumulator, multiplicand, multiplier and counter are all cleared.
  - in_ready rises on the first edge with reset_n = 1.
  - Reset has priority in every state: an in-flight computation is aborted and its result is never presented.
- Range: max |x| = 2^(W-1), so max result = 2*2^(N-2) = 2^(N-1). The N-bit result is always exact; no saturation or overflow path.
- in_ready is registered. It is 1 only in IDLE, and drops on the accepting edge.
- Accept: an edge with in_valid & in_ready.
  - x and y are captured; later changes on x, y or in_valid are ignored until the next IDLE.
  - mag = |x| as W-bit unsigned (-2^(W-1) maps to 2^(W-1)).
  - mcand = mag zero-extended to N bits; mplier = mag; acc = 0; cnt = 0.
  - State goes to MUL_X.
- MUL_X, one step per edge:
  - if mplier[0], acc += mcand
  - mcand <<= 1; mplier >>= 1; cnt += 1
  - After W steps (cnt == W-1 on the step edge): reload mcand and mplier from |y|, cnt = 0, acc retained, state goes to MUL_Y.
- MUL_Y: identical step rule. After W steps: sum <= acc (including the final add), out_valid <= 1, state goes to DONE.
- Latency: out_valid is high after exactly 2W edges following the accepting edge (16 for N = 16). Latency is independent of data: no early termination.
- DONE:
  - sum and out_valid are held stable while out_ready = 0; in_ready stays 0.
  - On an edge with out_valid & out_ready: out_valid <= 0, in_ready <= 1, state goes to IDLE. sum keeps its last value.
- Throughput: at most one pair per 2W+2 cycles. No accept is possible in the same cycle as the output handshake.
- Counter width is $clog2(W). Counter wrap is not relied on: the terminal compare is explicit.
- An illegal state encoding returns to IDLE with out_valid = 0 and in_ready = 1.

Test Plan:
- N=16, x=3, y=4, out_ready=1 -> out_valid high exactly 16 edges after accept, sum=25 (sqrt downstream gives 5), one-cycle out_valid pulse, in_ready returns 1 the next cycle.
- x=-128, y=-128 -> sum=32768 (0x8000). Then x=127, y=-128 -> sum=32513. Checks the most-negative abs() handling and the full range.
- x=0, y=0 -> sum=0 with the same 16-edge latency. Then x=-1, y=1 -> sum=2.
- Backpressure: x=5, y=12, out_ready=0 for 5 cycles after out_valid -> sum=169 and out_valid held; in_ready=0; in_valid pulses with x=9 during the wait are ignored; release -> single handshake, then IDLE.
- Input churn: x and y change every cycle after accept (accept x=6, y=8) -> sum=100. Back-to-back in_valid held high -> second accept occurs exactly 2W+2 cycles after the first.
- Reset mid-operation: assert reset_n=0 for 1 edge during MUL_Y -> out_valid=0, sum=0, in_ready=0 on that edge, in_ready=1 one edge after release. No stale result appears. The next pair x=1, y=1 gives sum=2.
